// File: rtl/gpio_debounce_pkg.sv
// Shared register offsets, version code and counter helpers for the gpio input conditioner.
package gpio_debounce_pkg;

   localparam logic [7:0]  VERSION       = 8'd1;

   localparam logic [15:0] OFF_VERSION   = 16'd0;
   localparam logic [15:0] OFF_DEB_OUT   = 16'd1;
   localparam logic [15:0] OFF_RISE_FLAG = 16'd2;
   localparam logic [15:0] OFF_FALL_FLAG = 16'd3;
   localparam logic [15:0] OFF_IRQ_MASK  = 16'd4;
   localparam logic [15:0] OFF_RISE_CNT  = 16'd8;

   localparam logic [7:0]  CNT_MAX       = 8'hff;

   function automatic logic [7:0] sat_inc(input logic [7:0] val, input logic inc);
      return (inc && (val != CNT_MAX)) ? val + 8'd1 : val;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: two-flop synchronizer, stability counter and a one-cycle
// pulse on every debounced transition.
module debounce_channel #(
   parameter int   DEBOUNCE_CYCLES = 1024,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic in_raw,
   output logic deb_out,
   output logic edge_pulse
);

   localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         sync_q     <= {2{RESET_LEVEL}};
         cnt_q      <= '0;
         deb_out    <= RESET_LEVEL;
         edge_pulse <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], in_raw};
         edge_pulse <= 1'b0;
         // Any return to the current level restarts the stability window.
         if (sync_q[1] == deb_out) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            deb_out    <= ~deb_out;
            cnt_q      <= '0;
            edge_pulse <= 1'b1;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/gpio_debounce.sv
// Bus-attached pad input conditioner: per-channel debounce, edge flags,
// saturating rise counters and a maskable registered interrupt.
module gpio_debounce
   import gpio_debounce_pkg::*;
#(
   parameter logic [15:0] BASEADDR        = 16'h0000,
   parameter logic [15:0] HIGHADDR        = 16'h000f,
   parameter int          IO_WIDTH        = 8,
   parameter int          DEBOUNCE_CYCLES = 1024,
   parameter logic [7:0]  RESET_LEVEL     = 8'h00
) (
   input  logic                BUS_CLK,
   input  logic                BUS_RST_N,
   input  logic [15:0]         BUS_ADD,
   inout  wire  [7:0]          BUS_DATA,
   input  logic                BUS_RD,
   input  logic                BUS_WR,
   input  logic [IO_WIDTH-1:0] IN_RAW,
   output logic [IO_WIDTH-1:0] DEB_OUT,
   output logic [IO_WIDTH-1:0] EDGE_PULSE,
   output logic                IRQ
);

   logic [IO_WIDTH-1:0] deb;
   logic [IO_WIDTH-1:0] edge_p;
   logic [IO_WIDTH-1:0] rise;
   logic [IO_WIDTH-1:0] fall;

   for (genvar i = 0; i < IO_WIDTH; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .RESET_LEVEL    (RESET_LEVEL[i])
      ) u_ch (
         .clk_sys   (BUS_CLK),
         .rst_b     (BUS_RST_N),
         .in_raw    (IN_RAW[i]),
         .deb_out   (deb[i]),
         .edge_pulse(edge_p[i])
      );
   end

   assign DEB_OUT    = deb;
   assign EDGE_PULSE = edge_p;
   // The pulse follows the toggle, so deb already holds the new level.
   assign rise       = edge_p & deb;
   assign fall       = edge_p & ~deb;

   logic [15:0]         offset;
   logic                in_win;
   logic                wr_en;
   logic                rd_en;
   logic                soft_clr;
   logic [IO_WIDTH-1:0] wbits;

   assign offset   = BUS_ADD - BASEADDR;
   assign in_win   = (BUS_ADD >= BASEADDR) && (BUS_ADD <= HIGHADDR);
   assign wr_en    = BUS_WR && in_win;
   assign rd_en    = BUS_RD && in_win;
   assign soft_clr = wr_en && (offset == OFF_VERSION);
   assign wbits    = BUS_DATA[IO_WIDTH-1:0];

   logic [IO_WIDTH-1:0] rise_flag_q, rise_flag_d;
   logic [IO_WIDTH-1:0] fall_flag_q, fall_flag_d;
   logic [IO_WIDTH-1:0] mask_q, mask_d;
   logic [7:0]          rise_cnt_q [IO_WIDTH];
   logic [7:0]          rise_cnt_d [IO_WIDTH];

   // Clears are applied first so an edge in the same cycle always survives.
   always_comb begin
      rise_flag_d = rise_flag_q;
      fall_flag_d = fall_flag_q;
      mask_d      = mask_q;
      if (soft_clr) begin
         rise_flag_d = '0;
         fall_flag_d = '0;
         mask_d      = '0;
      end
      if (wr_en && (offset == OFF_RISE_FLAG)) rise_flag_d = rise_flag_d & ~wbits;
      if (wr_en && (offset == OFF_FALL_FLAG)) fall_flag_d = fall_flag_d & ~wbits;
      if (wr_en && (offset == OFF_IRQ_MASK))  mask_d      = wbits;
      rise_flag_d = rise_flag_d | rise;
      fall_flag_d = fall_flag_d | fall;
   end

   always_comb begin
      for (int i = 0; i < IO_WIDTH; i++) begin
         rise_cnt_d[i] = rise_cnt_q[i];
         if (soft_clr || (wr_en && (offset == OFF_RISE_CNT + 16'(i)))) rise_cnt_d[i] = 8'd0;
         rise_cnt_d[i] = sat_inc(rise_cnt_d[i], rise[i]);
      end
   end

   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         rise_flag_q <= '0;
         fall_flag_q <= '0;
         mask_q      <= '0;
         IRQ         <= 1'b0;
         for (int i = 0; i < IO_WIDTH; i++) rise_cnt_q[i] <= 8'd0;
      end else begin
         rise_flag_q <= rise_flag_d;
         fall_flag_q <= fall_flag_d;
         mask_q      <= mask_d;
         IRQ         <= |((rise_flag_q | fall_flag_q) & mask_q);
         for (int i = 0; i < IO_WIDTH; i++) rise_cnt_q[i] <= rise_cnt_d[i];
      end
   end

   logic [7:0] rd_mux;
   logic [7:0] rd_data_q;
   logic       rd_oe_q;

   always_comb begin
      rd_mux = 8'h00;
      case (offset)
         OFF_VERSION:   rd_mux = VERSION;
         OFF_DEB_OUT:   rd_mux[IO_WIDTH-1:0] = deb;
         OFF_RISE_FLAG: rd_mux[IO_WIDTH-1:0] = rise_flag_q;
         OFF_FALL_FLAG: rd_mux[IO_WIDTH-1:0] = fall_flag_q;
         OFF_IRQ_MASK:  rd_mux[IO_WIDTH-1:0] = mask_q;
         default:       rd_mux = 8'h00;
      endcase
      for (int i = 0; i < IO_WIDTH; i++) begin
         if (offset == OFF_RISE_CNT + 16'(i)) rd_mux = rise_cnt_q[i];
      end
   end

   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         rd_data_q <= 8'h00;
         rd_oe_q   <= 1'b0;
      end else begin
         rd_oe_q <= rd_en;
         if (rd_en) rd_data_q <= rd_mux;
      end
   end

   assign BUS_DATA = rd_oe_q ? rd_data_q : 8'hzz;

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce with 8 channels and a 16-cycle debounce window.
module tb_gpio_debounce;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] bus_add = 16'h0000;
   wire  [7:0]  bus_data;
   logic        bus_rd = 1'b0;
   logic        bus_wr = 1'b0;
   logic [7:0]  tb_wdata = 8'h00;
   logic        tb_oe = 1'b0;
   logic [7:0]  in_raw = 8'h00;
   logic [7:0]  deb_out;
   logic [7:0]  edge_pulse;
   logic        irq;

   int total = 0;
   int bad   = 0;

   assign bus_data = tb_oe ? tb_wdata : 8'hzz;

   always #5 clk = ~clk;

   gpio_debounce #(
      .BASEADDR       (16'h0000),
      .HIGHADDR       (16'h000f),
      .IO_WIDTH       (8),
      .DEBOUNCE_CYCLES(16),
      .RESET_LEVEL    (8'h00)
   ) dut (
      .BUS_CLK   (clk),
      .BUS_RST_N (rst_n),
      .BUS_ADD   (bus_add),
      .BUS_DATA  (bus_data),
      .BUS_RD    (bus_rd),
      .BUS_WR    (bus_wr),
      .IN_RAW    (in_raw),
      .DEB_OUT   (deb_out),
      .EDGE_PULSE(edge_pulse),
      .IRQ       (irq)
   );

   // All bus tasks start and end on a falling edge.
   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      bus_add  = a;
      tb_wdata = d;
      tb_oe    = 1'b1;
      bus_wr   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_wr = 1'b0;
      tb_oe  = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
      bus_add = a;
      bus_rd  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_rd = 1'b0;
      d = bus_data;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      logic [7:0] d;
      rst_n = 1'b0;
      idle(3);
      total++; if (deb_out !== 8'h00) begin bad++; $display("FAIL reset_deb got=%h exp=%h", deb_out, 8'h00); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
      rst_n = 1'b1;
      idle(2);
      bus_read(16'd0, d);
      total++; if (d !== 8'h01) begin bad++; $display("FAIL reg0_version got=%h exp=%h", d, 8'h01); end
      bus_read(16'd1, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL reg1_reset got=%h exp=%h", d, 8'h00); end
      bus_read(16'd2, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL reg2_reset got=%h exp=%h", d, 8'h00); end
      bus_read(16'd5, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL reg5_unmapped got=%h exp=%h", d, 8'h00); end
   endtask

   task automatic test_rise_latency;
      logic [7:0] d;
      in_raw[0] = 1'b1;
      repeat (17) @(posedge clk);
      @(negedge clk);
      total++; if (deb_out[0] !== 1'b0) begin bad++; $display("FAIL lat17_deb got=%b exp=0", deb_out[0]); end
      @(negedge clk);
      total++; if (deb_out[0] !== 1'b1) begin bad++; $display("FAIL lat18_deb got=%b exp=1", deb_out[0]); end
      total++; if (edge_pulse !== 8'h01) begin bad++; $display("FAIL lat18_pulse got=%h exp=%h", edge_pulse, 8'h01); end
      @(negedge clk);
      total++; if (edge_pulse !== 8'h00) begin bad++; $display("FAIL pulse_width got=%h exp=%h", edge_pulse, 8'h00); end
      bus_read(16'd2, d);
      total++; if (d !== 8'h01) begin bad++; $display("FAIL rise_flag0 got=%h exp=%h", d, 8'h01); end
      bus_read(16'd8, d);
      total++; if (d !== 8'h01) begin bad++; $display("FAIL rise_cnt0 got=%h exp=%h", d, 8'h01); end
   endtask

   task automatic test_glitch;
      logic [7:0] d;
      logic       moved;
      moved = 1'b0;
      for (int seg = 0; seg < 20; seg++) begin
         in_raw[3] = ~in_raw[3];
         repeat (10) begin
            @(negedge clk);
            if (deb_out[3] !== 1'b0 || edge_pulse[3] !== 1'b0) moved = 1'b1;
         end
      end
      total++; if (moved !== 1'b0) begin bad++; $display("FAIL glitch_moved got=%b exp=0", moved); end
      idle(25);
      total++; if (deb_out !== 8'h01) begin bad++; $display("FAIL glitch_deb got=%h exp=%h", deb_out, 8'h01); end
      bus_read(16'd2, d);
      total++; if (d !== 8'h01) begin bad++; $display("FAIL glitch_rise_flag got=%h exp=%h", d, 8'h01); end
      bus_read(16'd3, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL glitch_fall_flag got=%h exp=%h", d, 8'h00); end
      bus_read(16'd11, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL glitch_cnt3 got=%h exp=%h", d, 8'h00); end
   endtask

   task automatic test_saturate;
      logic [7:0] d;
      for (int n = 0; n < 300; n++) begin
         in_raw[1] = 1'b1;
         idle(20);
         in_raw[1] = 1'b0;
         idle(20);
      end
      bus_read(16'd9, d);
      total++; if (d !== 8'hff) begin bad++; $display("FAIL sat_cnt1 got=%h exp=%h", d, 8'hff); end
      bus_read(16'd3, d);
      total++; if (d !== 8'h02) begin bad++; $display("FAIL sat_fall_flag got=%h exp=%h", d, 8'h02); end
      bus_read(16'd2, d);
      total++; if (d !== 8'h03) begin bad++; $display("FAIL sat_rise_flag got=%h exp=%h", d, 8'h03); end
      bus_write(16'd9, 8'h5a);
      bus_read(16'd9, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL cnt1_clear got=%h exp=%h", d, 8'h00); end
      bus_read(16'd8, d);
      total++; if (d !== 8'h01) begin bad++; $display("FAIL cnt0_kept got=%h exp=%h", d, 8'h01); end
   endtask

   task automatic test_irq;
      logic [7:0] d;
      bus_write(16'd0, 8'hff);
      bus_read(16'd2, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL soft_clr_rise got=%h exp=%h", d, 8'h00); end
      bus_read(16'd8, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL soft_clr_cnt0 got=%h exp=%h", d, 8'h00); end
      bus_read(16'd1, d);
      total++; if (d !== 8'h01) begin bad++; $display("FAIL soft_clr_deb got=%h exp=%h", d, 8'h01); end

      bus_write(16'd4, 8'h01);
      idle(2);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_idle got=%b exp=0", irq); end
      in_raw[0] = 1'b0;
      idle(25);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_fall got=%b exp=1", irq); end
      bus_write(16'd3, 8'h01);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_clr_lag got=%b exp=1", irq); end
      @(negedge clk);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clr got=%b exp=0", irq); end

      in_raw[0] = 1'b1;
      repeat (19) @(posedge clk);
      @(negedge clk);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_rise_lag got=%b exp=0", irq); end
      @(negedge clk);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b exp=1", irq); end

      in_raw[0] = 1'b0;
      idle(25);
      bus_write(16'd3, 8'h01);
      in_raw[0] = 1'b1;
      repeat (18) @(posedge clk);
      @(negedge clk);
      bus_write(16'd2, 8'h01);
      @(negedge clk);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_w1c_race got=%b exp=1", irq); end
      bus_read(16'd2, d);
      total++; if (d !== 8'h01) begin bad++; $display("FAIL flag_w1c_race got=%h exp=%h", d, 8'h01); end
      bus_read(16'd8, d);
      total++; if (d !== 8'h02) begin bad++; $display("FAIL cnt0_two got=%h exp=%h", d, 8'h02); end

      in_raw[0] = 1'b0;
      idle(25);
      in_raw[0] = 1'b1;
      repeat (18) @(posedge clk);
      @(negedge clk);
      bus_write(16'd8, 8'h00);
      bus_read(16'd8, d);
      total++; if (d !== 8'h01) begin bad++; $display("FAIL cnt_clr_race got=%h exp=%h", d, 8'h01); end

      bus_write(16'd3, 8'h01);
      idle(2);
      bus_write(16'd2, 8'h01);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_final_lag got=%b exp=1", irq); end
      @(negedge clk);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_final_clr got=%b exp=0", irq); end
   endtask

   task automatic test_reset_mid_debounce;
      in_raw = 8'h05;
      repeat (12) @(posedge clk);
      @(negedge clk);
      total++; if (deb_out !== 8'h01) begin bad++; $display("FAIL pre_rst_deb got=%h exp=%h", deb_out, 8'h01); end
      rst_n = 1'b0;
      #1;
      total++; if (deb_out !== 8'h00) begin bad++; $display("FAIL rst_async_deb got=%h exp=%h", deb_out, 8'h00); end
      idle(2);
      rst_n = 1'b1;
      repeat (17) @(posedge clk);
      @(negedge clk);
      total++; if (deb_out !== 8'h00) begin bad++; $display("FAIL post_rst17 got=%h exp=%h", deb_out, 8'h00); end
      @(negedge clk);
      total++; if (deb_out !== 8'h05) begin bad++; $display("FAIL post_rst18 got=%h exp=%h", deb_out, 8'h05); end
   endtask

   initial begin
      test_reset();
      test_rise_latency();
      test_glitch();
      test_saturate();
      test_irq();
      test_reset_mid_debounce();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
